// File: rtl/selector_secuenciador.sv
// Upstream driver for the synchronous 4:1 mux: accepts 4-bit words on valid/ready,
// holds each word and walks the selector through all four bit positions.
module selector_secuenciador #(
    parameter int HOLD_CYCLES = 1,
    parameter bit MSB_FIRST   = 1'b0
) (
    input  logic       iClk,
    input  logic       iReset,
    input  logic [3:0] iWord,
    input  logic       iValid,
    output logic       oReady,
    output logic [3:0] oData,
    output logic [1:0] oSelector,
    output logic       oSelValid,
    output logic       oBitValid,
    output logic       oLastBit,
    output logic       oBusy
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam logic [1:0] SEL_START = MSB_FIRST ? 2'b11 : 2'b00;
    localparam logic [1:0] SEL_FINAL = MSB_FIRST ? 2'b00 : 2'b11;
    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

    // Selector walk direction follows the configured bit order.
    function automatic logic [1:0] sel_step(input logic [1:0] sel);
        logic [1:0] nxt;
        if (MSB_FIRST) begin
            nxt = sel - 2'b01;
        end else begin
            nxt = sel + 2'b01;
        end
        return nxt;
    endfunction

    state_t     state_q, state_d;
    logic [3:0] data_q, data_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] cnt_q, cnt_d;
    logic       sel_valid_q, sel_valid_d;
    logic       bit_valid_q, bit_valid_d;
    logic       last_bit_q, last_bit_d;
    logic       busy_q, busy_d;

    logic       hold_done_s;
    logic       end_of_word_s;
    logic       ready_s;
    logic       accept_s;

    // Handshake decode: ready in IDLE and in the single end-of-word cycle.
    always_comb begin
        hold_done_s   = (cnt_q == HOLD_LAST);
        end_of_word_s = (state_q == ST_SHIFT) && (sel_q == SEL_FINAL) && hold_done_s;
        ready_s       = (state_q == ST_IDLE) || end_of_word_s;
        accept_s      = iValid && ready_s;
    end

    // Next-state, selector stepping and delayed qualifier computation.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_SHIFT;
                    data_d  = iWord;
                    sel_d   = SEL_START;
                    cnt_d   = 4'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (accept_s) begin
                    // Back-to-back word: restart the walk with no idle gap.
                    state_d = ST_SHIFT;
                    data_d  = iWord;
                    sel_d   = SEL_START;
                    cnt_d   = 4'd0;
                end else if (end_of_word_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else if (hold_done_s) begin
                    cnt_d = 4'd0;
                    sel_d = sel_step(sel_q);
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                data_d  = 4'd0;
                sel_d   = SEL_START;
                cnt_d   = 4'd0;
            end
        endcase

        sel_valid_d = (state_d == ST_SHIFT);
        busy_d      = (state_d == ST_SHIFT);
        // The mux registers its output, so its qualifiers trail by one cycle.
        bit_valid_d = sel_valid_q;
        last_bit_d  = sel_valid_q && end_of_word_s;
    end

    // State and output registers; reset dominates any handshake in flight.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            state_q     <= ST_IDLE;
            data_q      <= 4'd0;
            sel_q       <= SEL_START;
            cnt_q       <= 4'd0;
            sel_valid_q <= 1'b0;
            bit_valid_q <= 1'b0;
            last_bit_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            sel_valid_q <= sel_valid_d;
            bit_valid_q <= bit_valid_d;
            last_bit_q  <= last_bit_d;
            busy_q      <= busy_d;
        end
    end

    assign oReady    = ready_s;
    assign oData     = data_q;
    assign oSelector = sel_q;
    assign oSelValid = sel_valid_q;
    assign oBitValid = bit_valid_q;
    assign oLastBit  = last_bit_q;
    assign oBusy     = busy_q;

endmodule

// File: tb/tb_selector_secuenciador.sv
// Randomized bench: three configurations share one stimulus stream and are each
// compared against a cycle-count model of the word/bit schedule.
module tb_selector_secuenciador;

    localparam int NI = 3;

    logic             iClk;
    logic             iReset;
    logic [3:0]       iWord;
    logic             iValid;
    logic [NI-1:0]    rdy;
    logic [NI-1:0][3:0] dat;
    logic [NI-1:0][1:0] sel;
    logic [NI-1:0]    selv;
    logic [NI-1:0]    bitv;
    logic [NI-1:0]    lastb;
    logic [NI-1:0]    busy;

    int total;
    int bad;

    int         hc[NI];
    bit         mf[NI];
    bit         m_busy[NI];
    int         m_e[NI];
    logic [3:0] m_data[NI];
    bit         m_bv[NI];
    bit         m_lb[NI];
    bit         m_rst;

    selector_secuenciador #(.HOLD_CYCLES(1), .MSB_FIRST(1'b0)) u0 (
        .iClk(iClk), .iReset(iReset), .iWord(iWord), .iValid(iValid),
        .oReady(rdy[0]), .oData(dat[0]), .oSelector(sel[0]), .oSelValid(selv[0]),
        .oBitValid(bitv[0]), .oLastBit(lastb[0]), .oBusy(busy[0]));

    selector_secuenciador #(.HOLD_CYCLES(3), .MSB_FIRST(1'b0)) u1 (
        .iClk(iClk), .iReset(iReset), .iWord(iWord), .iValid(iValid),
        .oReady(rdy[1]), .oData(dat[1]), .oSelector(sel[1]), .oSelValid(selv[1]),
        .oBitValid(bitv[1]), .oLastBit(lastb[1]), .oBusy(busy[1]));

    selector_secuenciador #(.HOLD_CYCLES(1), .MSB_FIRST(1'b1)) u2 (
        .iClk(iClk), .iReset(iReset), .iWord(iWord), .iValid(iValid),
        .oReady(rdy[2]), .oData(dat[2]), .oSelector(sel[2]), .oSelValid(selv[2]),
        .oBitValid(bitv[2]), .oLastBit(lastb[2]), .oBusy(busy[2]));

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int word_len(input int i);
        return 4 * hc[i];
    endfunction

    function automatic bit exp_ready(input int i);
        return !m_busy[i] || (m_e[i] == word_len(i) - 1);
    endfunction

    function automatic int exp_index(input int i);
        int pos;
        pos = m_e[i] / hc[i];
        return mf[i] ? (3 - pos) : pos;
    endfunction

    // Model advance for one rising edge, using the inputs the DUT samples.
    task automatic model_step();
        bit nbv, nlb, rd;
        m_rst = iReset;
        for (int i = 0; i < NI; i++) begin
            if (iReset) begin
                m_busy[i] = 1'b0; m_e[i] = 0; m_data[i] = 4'd0;
                m_bv[i] = 1'b0; m_lb[i] = 1'b0;
            end else begin
                nbv = m_busy[i];
                nlb = m_busy[i] && (m_e[i] == word_len(i) - 1);
                rd  = exp_ready(i);
                if (iValid && rd) begin
                    m_busy[i] = 1'b1; m_e[i] = 0; m_data[i] = iWord;
                end else if (m_busy[i]) begin
                    if (m_e[i] == word_len(i) - 1) m_busy[i] = 1'b0;
                    else m_e[i] = m_e[i] + 1;
                end
                m_bv[i] = nbv;
                m_lb[i] = nlb;
            end
        end
    endtask

    task automatic check_all();
        int idx;
        for (int i = 0; i < NI; i++) begin
            check_eq($sformatf("u%0d.ready", i), 32'(rdy[i]), 32'(exp_ready(i)));
            check_eq($sformatf("u%0d.data", i), 32'(dat[i]), 32'(m_data[i]));
            check_eq($sformatf("u%0d.selvalid", i), 32'(selv[i]), 32'(m_busy[i]));
            check_eq($sformatf("u%0d.busy", i), 32'(busy[i]), 32'(m_busy[i]));
            check_eq($sformatf("u%0d.bitvalid", i), 32'(bitv[i]), 32'(m_bv[i]));
            check_eq($sformatf("u%0d.lastbit", i), 32'(lastb[i]), 32'(m_lb[i]));
            if (m_busy[i]) begin
                idx = exp_index(i);
                check_eq($sformatf("u%0d.selector", i), 32'(sel[i]), 32'(idx));
                check_eq($sformatf("u%0d.muxbit", i), 32'(dat[i][sel[i]]), 32'(m_data[i][idx]));
            end
            if (m_rst) begin
                check_eq($sformatf("u%0d.rst_sel", i), 32'(sel[i]), mf[i] ? 32'd3 : 32'd0);
            end
        end
    endtask

    initial begin
        int phase;
        total = 0;
        bad   = 0;
        hc[0] = 1; mf[0] = 1'b0;
        hc[1] = 3; mf[1] = 1'b0;
        hc[2] = 1; mf[2] = 1'b1;
        iReset = 1'b1;
        iValid = 1'b1;
        iWord  = 4'hF;
        repeat (2) begin
            @(posedge iClk);
            model_step();
        end
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge iClk);
            check_all();
            phase  = cyc / 500;
            iWord  = 4'($urandom_range(0, 15));
            iReset = 1'b0;
            case (phase)
                0: iValid = ($urandom_range(0, 1) == 0);
                1: iValid = 1'b1;
                2: iValid = ($urandom_range(0, 3) == 0);
                default: begin
                    iValid = ($urandom_range(0, 2) != 0);
                    iReset = ($urandom_range(0, 29) == 0);
                end
            endcase
            @(posedge iClk);
            model_step();
        end
        @(negedge iClk);
        check_all();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/selector_secuenciador.md
Name: selector_secuenciador

Overview:
- Upstream driver for the team's synchronous 4:1 multiplexer. It feeds that mux's 4-bit data input and 2-bit selector input.
- Accepts 4-bit words on a valid/ready handshake, holds each word stable and steps the selector through all four bit positions, so the mux emits the word serially.
- Produces qualifier flags delayed one cycle, to line up with the mux's registered output.

Parameters:
- HOLD_CYCLES, 1: clock cycles each selector value is held; legal range 1..16.
- MSB_FIRST, 0: 0 = selector order 00,01,10,11; 1 = order 11,10,01,00.

Ports:
- iClk  in  1  clock; all logic on rising edge.
- iReset  in  1  synchronous reset, active-high.
- iWord  in  4  word to serialize.
- iValid  in  1  iWord is valid.
- oReady  out  1  block accepts iWord this cycle.
- oData  out  4  held word; connects to the mux data input.
- oSelector  out  2  bit index; connects to the mux selector input.
- oSelValid  out  1  oData/oSelector currently present a valid bit.
- oBitValid  out  1  oSelValid delayed 1 cycle; qualifies the mux output.
- oLastBit  out  1  delayed 1 cycle; qualifies the 4th bit of a word at the mux output.
- oBusy  out  1  a word is being serialized.

Behaviour:
- Reset is synchronous, active-high. At the edge with iReset=1:
  - state=IDLE; oData=0; oSelector=start value (00, or 11 if MSB_FIRST); hold counter=0.
  - oSelValid=0, oBitValid=0, oLastBit=0, oBusy=0.
- Reset has priority over every other event, including mid-word. The word in progress is discarded with no partial flag. iValid is ignored while iReset=1.
- States:
  - IDLE: oReady=1, oSelValid=0.
  - SHIFT: oSelValid=1, oBusy=1.
- Accept: on an edge where iValid=1 and oReady=1:
  - oData<=iWord, oSelector<=start value, hold counter<=0, state<=SHIFT.
  - oSelValid is 1 in the cycle after the accepting edge.
- SHIFT stepping:
  - Each edge, the hold counter increments.
  - When the counter reaches HOLD_CYCLES-1, it resets to 0 and oSelector advances: +1, or -1 if MSB_FIRST.
  - oData is stable for the whole word, 4*HOLD_CYCLES cycles.
- End of word = final selector value (11 or 00) with hold counter = HOLD_CYCLES-1.
  - oReady=1 only in that cycle; it is 0 in every other SHIFT cycle. oReady is combinational from state and counters.
  - If iValid=1 in that cycle: accept the new word, no gap; selector restarts at the start value next cycle.
  - If iValid=0: state<=IDLE, oSelValid drops next cycle.
- Output alignment (mux latency is 1 cycle):
  - oBitValid <= oSelValid.
  - oLastBit <= oSelValid AND final selector value AND hold counter = HOLD_CYCLES-1.
  - With HOLD_CYCLES>1, oBitValid stays high for every held cycle.
- Stall: in IDLE with iValid=0, all outputs hold; oData keeps the last word.
- iWord changing during SHIFT has no effect.
- oBusy = (state==SHIFT).
- Throughput: one word per 4*HOLD_CYCLES cycles when iValid is held high.

Test Plan:
1. HOLD_CYCLES=1, MSB_FIRST=0, iWord=4'hD (1101) accepted at edge k -> oSelector 00,01,10,11 in cycles k+1..k+4; oSelValid high k+1..k+4; mux output 1,0,1,1 with oBitValid high k+2..k+5; oLastBit only at k+5; oReady back to 1 at k+5 (IDLE).
2. Back-to-back, iValid held 1 with 4'hD then 4'h6 -> second accepted at edge k+4 (oReady=1 in cycle k+4); selector 00..11 repeats with no idle cycle; mux output 1,0,1,1,0,1,1,0; oBitValid continuously high k+2..k+9.
3. HOLD_CYCLES=3, iWord=4'hA -> each selector value held 3 cycles (12 cycles total); mux output 0,0,0,1,1,1,0,0,0,1,1,1; oReady=1 only in the 12th SHIFT cycle.
4. MSB_FIRST=1, iWord=4'h8 -> oSelector 11,10,01,00; mux output 1,0,0,0; oLastBit on the bit from index 00.
5. iReset=1 for one edge while oSelector=10 mid-word -> next cycle state IDLE, oSelValid=0, oBusy=0, oData=0, oReady=1; oBitValid=0 one cycle later; no oLastBit for the aborted word.
6. iValid=1 while oReady=0 mid-word with a different iWord -> ignored; oData unchanged; that word accepted only in the end-of-word cycle if still presented.
